// File: rtl/toothless_pkg.sv
// Shared types for the toothless core load/store path.
//   data_type_e   : access size encoding from decode (2'b11 is illegal).
//   lsu_state_e   : load/store unit sequencing states.
//   LSU_BE_*      : byte-enable patterns before lane shifting.
//   is_misaligned : true when an access cannot be issued as a single bus beat.
package toothless_pkg;

  typedef enum logic [1:0] {
    DT_BYTE = 2'b00,
    DT_HALF = 2'b01,
    DT_WORD = 2'b10
  } data_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'b00,
    LSU_WAIT_GNT    = 2'b01,
    LSU_WAIT_RVALID = 2'b10
  } lsu_state_e;

  localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
  localparam logic [3:0] LSU_BE_HALF = 4'b0011;
  localparam logic [3:0] LSU_BE_WORD = 4'b1111;

  // The unused type encoding is folded into "misaligned" so it takes the
  // same error path and never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] dtype,
                                         input logic [1:0] addr_lo);
    case (dtype)
      DT_BYTE: return 1'b0;
      DT_HALF: return addr_lo[0];
      DT_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit (32-bit bus).
//   req_type/req_offset/req_wdata -> req_be, req_wdata_lanes (store side)
//   rsp_type/rsp_offset/rsp_sign_ext/rsp_rdata_raw -> rsp_rdata (load side)
module lsu_align
  import toothless_pkg::*;
(
  input  logic [1:0]  req_type,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_lanes,
  input  logic [1:0]  rsp_type,
  input  logic [1:0]  rsp_offset,
  input  logic        rsp_sign_ext,
  input  logic [31:0] rsp_rdata_raw,
  output logic [31:0] rsp_rdata
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  assign rsp_byte = rsp_rdata_raw[{rsp_offset, 3'b000} +: 8];
  assign rsp_half = rsp_rdata_raw[{rsp_offset[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    req_be          = 4'b0000;
    req_wdata_lanes = req_wdata;
    case (req_type)
      DT_BYTE: begin
        req_be          = LSU_BE_BYTE << req_offset;
        req_wdata_lanes = {4{req_wdata[7:0]}};
      end
      DT_HALF: begin
        req_be          = LSU_BE_HALF << {req_offset[1], 1'b0};
        req_wdata_lanes = {2{req_wdata[15:0]}};
      end
      DT_WORD: req_be = LSU_BE_WORD;
      default: req_be = 4'b0000;
    endcase
  end

  always_comb begin
    rsp_rdata = rsp_rdata_raw;
    case (rsp_type)
      DT_BYTE: rsp_rdata = {{24{rsp_sign_ext & rsp_byte[7]}}, rsp_byte};
      DT_HALF: rsp_rdata = {{16{rsp_sign_ext & rsp_half[15]}}, rsp_half};
      default: rsp_rdata = rsp_rdata_raw;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit controller: sequences one OBI-style data access per
// decoded LOAD/STORE and stalls the pipeline until it completes.
//   decode side : data_req_i, data_we_i, data_type_i, data_sign_ext_i,
//                 addr_i, wdata_i -> stall_o, rvalid_o, rdata_o, err_o
//   bus side    : mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
//                 <- mem_gnt_i, mem_rvalid_i, mem_rdata_i
// Optional macro LSU_TIMEOUT_EN adds a bus watchdog of TIMEOUT_CYCLES.
// Byte-lane logic assumes DATA_WIDTH = 32.
module lsu_controller
  import toothless_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  data_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [1:0]            type_q;
  logic                  sign_ext_q;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] rdata_ext;
  logic                  misaligned;
  logic                  accept;
  logic                  timeout_hit;

  lsu_align u_align (
    .req_type        (data_type_i),
    .req_offset      (addr_i[1:0]),
    .req_wdata       (wdata_i),
    .req_be          (be_next),
    .req_wdata_lanes (wdata_next),
    .rsp_type        (type_q),
    .rsp_offset      (addr_q[1:0]),
    .rsp_sign_ext    (sign_ext_q),
    .rsp_rdata_raw   (mem_rdata_i),
    .rsp_rdata       (rdata_ext)
  );

  assign misaligned = is_misaligned(data_type_i, addr_i[1:0]);

  // In the err_o cycle upstream still presents the faulting instruction
  // (it is about to advance), so it must not be accepted a second time.
  assign accept = (state_q == LSU_IDLE) && data_req_i && !err_o;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            leave_wait;

  assign timeout_hit = (state_q != LSU_IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign leave_wait  = ((state_q == LSU_WAIT_GNT) && mem_gnt_i)
                    || ((state_q == LSU_WAIT_RVALID) && mem_rvalid_i)
                    || timeout_hit;

  // Counts cycles spent in the current wait state; restarts on each change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wd_q <= '0;
    else if (state_q == LSU_IDLE || leave_wait) wd_q <= '0;
    else                                      wd_q <= wd_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      addr_q      <= '0;
      type_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              err_o <= 1'b1;
            end else begin
              addr_q      <= addr_i;
              type_q      <= data_type_i;
              sign_ext_q  <= data_sign_ext_i;
              mem_we_o    <= data_we_i;
              mem_be_o    <= be_next;
              mem_wdata_o <= wdata_next;
              mem_req_o   <= 1'b1;
              state_q     <= LSU_WAIT_GNT;
            end
          end
        end
        LSU_WAIT_GNT: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= LSU_WAIT_RVALID;
          end else if (timeout_hit) begin
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            state_q   <= LSU_IDLE;
          end
        end
        LSU_WAIT_RVALID: begin
          if (mem_rvalid_i) begin
            state_q <= LSU_IDLE;
          end else if (timeout_hit) begin
            err_o   <= 1'b1;
            state_q <= LSU_IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state_q   <= LSU_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o = {addr_q[DATA_WIDTH-1:2], 2'b00};

  // Response data is forwarded combinationally in its arrival cycle so the
  // register-file write and pipeline release happen together.
  assign rvalid_o = (state_q == LSU_WAIT_RVALID) && mem_rvalid_i && !mem_we_o;
  assign rdata_o  = rvalid_o ? rdata_ext : '0;

  // Gated by rst so the pipeline sees no stall while reset is held, even if
  // decode still presents a request.
  assign stall_o = !rst && (accept
                         || (state_q == LSU_WAIT_GNT)
                         || ((state_q == LSU_WAIT_RVALID) && !mem_rvalid_i));

endmodule

// File: tb/tb_lsu_controller.sv
module tb_lsu_controller;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i, data_we_i, data_sign_ext_i;
  logic [1:0]  data_type_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  lsu_controller #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_type_i(data_type_i),
    .data_sign_ext_i(data_sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle, written by the driver.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_rvalid, exp_err, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  // Values sampled at notable points of the last access.
  logic        cap_err, cap_req, cap_stall, cap_rvalid, cap_we;
  logic [31:0] cap_rdata, cap_wdata;
  logic [3:0]  cap_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---- transaction-level reference model ----
  function automatic int m_size(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'd3) return 1'b1;
    return (a % m_size(t)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] t, input logic [31:0] a);
    logic [3:0] be;
    int off = int'(a % 4);
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + m_size(t));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] wd);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % m_size(t)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] t, input logic [31:0] a,
                                          input logic sx, input logic [31:0] raw);
    longint v;
    int     bits = 8 * m_size(t);
    if (t == 2'd2) return raw;
    v = longint'((raw >> (8 * (a % 4)))) & ((64'sd1 <<< bits) - 1);
    if (sx && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // ---- compare process ----
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("stall_o", {31'b0, stall_o}, {31'b0, exp_stall});
      check("mem_req_o", {31'b0, mem_req_o}, {31'b0, exp_req});
      check("rvalid_o", {31'b0, rvalid_o}, {31'b0, exp_rvalid});
      check("err_o", {31'b0, err_o}, {31'b0, exp_err});
      check("rdata_o", rdata_o, exp_rdata);
      if (exp_req) begin
        check("mem_addr_o", mem_addr_o, exp_addr);
        check("mem_we_o", {31'b0, mem_we_o}, {31'b0, exp_we});
        check("mem_be_o", {28'b0, mem_be_o}, {28'b0, exp_be});
        check("mem_wdata_o", mem_wdata_o, exp_wdata);
      end
    end
  end

  // ---- driver ----
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_stall = 0; exp_req = 0; exp_rvalid = 0; exp_err = 0; exp_rdata = '0;
  endtask

  task automatic access(input logic we, input logic [1:0] t, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] raw,
                        input logic spurious);
    next_cycle();
    data_req_i = 1; data_we_i = we; data_type_i = t; data_sign_ext_i = sx;
    addr_i = a; wdata_i = wd; mem_gnt_i = 0; mem_rvalid_i = spurious;
    idle_exp(); exp_stall = 1;
    if (m_misaligned(t, a)) begin
      next_cycle();
      mem_rvalid_i = 0; exp_stall = 0; exp_err = 1;
      @(negedge clk);
      cap_err = err_o; cap_req = mem_req_o; cap_stall = stall_o;
      next_cycle();
      data_req_i = 0; idle_exp();
      return;
    end
    exp_addr = a & 32'hFFFF_FFFC; exp_we = we;
    exp_be = m_be(t, a); exp_wdata = m_wdata(t, wd);
    for (int i = 0; i < gd; i++) begin
      next_cycle();
      mem_rvalid_i = 0;
`ifdef LSU_TIMEOUT_EN
      if (i == TMO) begin
        exp_req = 0; exp_stall = 0; exp_err = 1;
        @(negedge clk);
        cap_err = err_o; cap_req = mem_req_o; cap_stall = stall_o;
        next_cycle();
        data_req_i = 0; idle_exp();
        return;
      end
`endif
      exp_req = 1; exp_stall = 1;
    end
    next_cycle();
    mem_gnt_i = 1; mem_rvalid_i = spurious; exp_req = 1; exp_stall = 1;
    @(negedge clk);
    cap_be = mem_be_o; cap_wdata = mem_wdata_o; cap_we = mem_we_o;
    for (int i = 0; i < rd; i++) begin
      next_cycle();
      mem_gnt_i = 0; mem_rvalid_i = 0; exp_req = 0; exp_stall = 1;
    end
    next_cycle();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = raw;
    exp_req = 0; exp_stall = 0; exp_rvalid = !we;
    exp_rdata = we ? 32'h0 : m_rdata(t, a, sx, raw);
    @(negedge clk);
    cap_rdata = rdata_o; cap_rvalid = rvalid_o; cap_stall = stall_o;
    next_cycle();
    data_req_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'hA5A5_A5A5; idle_exp();
  endtask

  initial begin
    rst = 1; data_req_i = 0; data_we_i = 0; data_type_i = 0; data_sign_ext_i = 0;
    addr_i = 0; wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    idle_exp();
    #12;
    check("reset stall_o", {31'b0, stall_o}, 32'h0);
    check("reset mem_req_o", {31'b0, mem_req_o}, 32'h0);
    check("reset mem_be_o", {28'b0, mem_be_o}, 32'h0);
    check("reset mem_addr_o", mem_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 0; chk_en = 1;
    next_cycle();

    // LW 0x100: gnt in cycle 2, rvalid in cycle 4
    access(0, 2'd2, 0, 32'h100, 32'h0, 1, 1, 32'hDEAD_BEEF, 0);
    check("lw be", {28'b0, cap_be}, 32'h0000_000F);
    check("lw rdata", cap_rdata, 32'hDEAD_BEEF);
    check("lw stall at rvalid", {31'b0, cap_stall}, 32'h0);

    // LB signed / LBU at 0x103
    access(0, 2'd0, 1, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF, 0);
    check("lb be", {28'b0, cap_be}, 32'h0000_0008);
    check("lb rdata", cap_rdata, 32'hFFFF_FF80);
    access(0, 2'd0, 0, 32'h103, 32'h0, 2, 0, 32'h80FF_FFFF, 0);
    check("lbu rdata", cap_rdata, 32'h0000_0080);

    // SH 0x102
    access(1, 2'd1, 0, 32'h102, 32'h1234_ABCD, 1, 2, 32'hFFFF_FFFF, 0);
    check("sh be", {28'b0, cap_be}, 32'h0000_000C);
    check("sh wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh we", {31'b0, cap_we}, 32'h1);
    check("sh rvalid", {31'b0, cap_rvalid}, 32'h0);

    // LW 0x101 misaligned
    access(0, 2'd2, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0);
    check("mis err", {31'b0, cap_err}, 32'h1);
    check("mis req", {31'b0, cap_req}, 32'h0);
    check("mis stall", {31'b0, cap_stall}, 32'h0);

    // Further patterns, including stray rvalid in IDLE and in the gnt cycle
    access(0, 2'd1, 1, 32'h202, 32'h0, 0, 1, 32'h8001_7FFF, 1);
    check("lh rdata", cap_rdata, 32'hFFFF_8001);
    access(1, 2'd0, 0, 32'h301, 32'h0000_0055, 0, 0, 32'h0, 0);
    check("sb be", {28'b0, cap_be}, 32'h0000_0002);
    check("sb wdata", cap_wdata, 32'h5555_5555);
    access(0, 2'd0, 0, 32'h001, 32'h0, 1, 0, 32'h1234_5678, 0);
    check("lbu lane1", cap_rdata, 32'h0000_0056);
    access(0, 2'd1, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0);
    check("lh mis err", {31'b0, cap_err}, 32'h1);
    access(0, 2'd3, 0, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    check("type11 err", {31'b0, cap_err}, 32'h1);

    // Grant withheld for longer than the watchdog limit
    access(0, 2'd2, 0, 32'h500, 32'h0, TMO + 6, 0, 32'h0BAD_F00D, 0);
`ifdef LSU_TIMEOUT_EN
    check("tmo err", {31'b0, cap_err}, 32'h1);
    check("tmo stall", {31'b0, cap_stall}, 32'h0);
`else
    check("long gnt rdata", cap_rdata, 32'h0BAD_F00D);
`endif

    // Reset in WAIT_RVALID, then a late response
    next_cycle();
    data_req_i = 1; data_we_i = 0; data_type_i = 2'd2; data_sign_ext_i = 0;
    addr_i = 32'h400; idle_exp(); exp_stall = 1;
    exp_addr = 32'h400; exp_we = 0; exp_be = 4'hF; exp_wdata = wdata_i;
    next_cycle();
    mem_gnt_i = 1; exp_req = 1;
    next_cycle();
    mem_gnt_i = 0; exp_req = 0;
    #1;
    chk_en = 0; rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_2222;
    #1;
    check("rst stall_o", {31'b0, stall_o}, 32'h0);
    check("rst mem_req_o", {31'b0, mem_req_o}, 32'h0);
    check("rst rvalid_o", {31'b0, rvalid_o}, 32'h0);
    check("rst mem_be_o", {28'b0, mem_be_o}, 32'h0);
    data_req_i = 0;
    @(posedge clk); #1;
    rst = 0; idle_exp(); chk_en = 1;
    next_cycle();
    mem_rvalid_i = 0;
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
